excess3_to_binary: RTL and testbench

//  Multi-digit excess-3 (XS-3) BCD to binary decoder: the return path for the binary-to-excess-3 converter.

---
 rtl/excess3_pkg.sv | 15 +
 rtl/xs3_digit_decode.sv | 14 +
 rtl/excess3_to_binary.sv | 103 ++++++++++
 tb/tb_excess3_to_binary.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/excess3_pkg.sv
// Shared constants and FSM encoding for the excess-3 to binary decoder.
// XS3_OFFSET/XS3_MIN/XS3_MAX bound the legal XS-3 digit codes.
package excess3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xs3_digit_decode.sv
// Single XS-3 digit decode: value = code - 3 (mod 16), plus an
// out-of-range flag for codes 0..2 and 13..15.
module xs3_digit_decode
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] val,
  output logic       invalid
);

  assign val     = code - XS3_OFFSET;
  assign invalid = (code < XS3_MIN) || (code > XS3_MAX);

endmodule

// File: rtl/excess3_to_binary.sv
// Multi-digit XS-3 to binary decoder, MSD first, one digit per clock.
// Define XS3_ERR_CHECK_EN to add the sticky per-word err output.
module excess3_to_binary
  import excess3_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*NDIG-1:0] din,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BW-1:0]   dout
`ifdef XS3_ERR_CHECK_EN
  ,
  output logic            err
`endif
);

  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t state, state_nx;

  logic [4*NDIG-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     acc;
  logic [3:0]        dig_val;
  logic              dig_bad;
  logic              accept;
  logic              last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);
  assign dout   = acc;

  xs3_digit_decode u_dec (
    .code    (sreg[4*NDIG-1 -: 4]),
    .val     (dig_val),
    .invalid (dig_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_CONV;
      end
      ST_CONV: begin
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // acc*10 as (acc<<3)+(acc<<1), wrapping at BW bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else if (accept) begin
      sreg <= din;
      cnt  <= '0;
      acc  <= '0;
    end else if (state == ST_CONV) begin
      sreg <= sreg << 4;
      cnt  <= cnt + CW'(1);
      acc  <= (acc << 3) + (acc << 1) + BW'(dig_val);
    end
  end

`ifdef XS3_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_q <= 1'b0;
    else if (accept)                       err_q <= 1'b0;
    else if (state == ST_CONV && dig_bad)  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_bad;
  assign unused_bad = dig_bad;
`endif

endmodule

// File: tb/tb_excess3_to_binary.sv
// Self-checking bench for excess3_to_binary (NDIG=3, BW=10),
// directed steps followed by a random sweep against an arithmetic model.
module tb_excess3_to_binary;

  localparam int NDIG = 3;
  localparam int BW   = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [11:0]   din;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] dout;
`ifdef XS3_ERR_CHECK_EN
  logic          err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  excess3_to_binary #(.NDIG(NDIG), .BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
`ifdef XS3_ERR_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decimal model: digit = (code-3) mod 16, value = sum of digit*10^k mod 2^BW
  function automatic int ref_dout(input logic [11:0] c);
    int acc = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      int d = int'(c[4*i +: 4]);
      acc = (acc * 10 + ((d + 13) % 16)) % (1 << BW);
    end
    return acc;
  endfunction

  function automatic bit ref_err(input logic [11:0] c);
    bit e = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      int d = int'(c[4*i +: 4]);
      if (d < 3 || d > 12) e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [11:0] encode(input int n);
    logic [11:0] c;
    c[11:8] = 4'(n / 100 + 3);
    c[7:4]  = 4'((n / 10) % 10 + 3);
    c[3:0]  = 4'(n % 10 + 3);
    return c;
  endfunction

  task automatic run_word(input logic [11:0] code, input int exp,
                          input bit experr, input int hold, input bit keep);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 1);
    din       = code;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    din = 12'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      check("busy_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, NDIG);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_dout", 32'(dout), exp);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    check("dout", 32'(dout), exp);
`ifdef XS3_ERR_CHECK_EN
    check("err", 32'(err), 32'(experr));
`else
    if (experr) n = 0;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("released_valid", 32'(out_valid), 0);
    check("released_ready", 32'(in_ready), 1);
  endtask

  initial begin
    logic [11:0] c;
    int          v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    // Async reset in the middle of a conversion
    @(negedge clk);
    din      = 12'h789;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_dout", 32'(dout), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
`ifdef XS3_ERR_CHECK_EN
    check("midrst_err", 32'(err), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_in_ready", 32'(in_ready), 1);
    check("postrst_out_valid", 32'(out_valid), 0);

    run_word(12'h789, 456, 1'b0, 0, 1'b0);
    run_word(12'h333, 0,   1'b0, 0, 1'b0);
    run_word(12'hCCC, 999, 1'b0, 0, 1'b0);
    run_word(12'h456, 123, 1'b0, 5, 1'b0);
    run_word(12'h3F3, 120, 1'b1, 1, 1'b0);
    run_word(12'h444, 111, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      v = int'($urandom_range(0, 999));
      run_word(encode(v), v, 1'b0, int'($urandom_range(0, 2)),
               1'($urandom));
    end

    for (int k = 0; k < 10; k++) begin
      c = 12'($urandom);
      run_word(c, ref_dout(c), ref_err(c), 0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
